// File: rtl/ps2_kbd_ctrl_if.sv
// Bus and host-side signal bundle for the PS/2 keyboard controller.
// The master modport is the controller; the slave modport is the port/host side.
interface ps2_kbd_ctrl_if;
  // PS/2 port CPU-style bus
  logic [7:0] ps2_d_in;
  logic [7:0] ps2_d_out;
  logic       ps2_d_oe;
  logic       ps2_n_sel;
  logic       ps2_n_oe;
  logic       ps2_n_we;
  logic       ps2_a;
  logic       ps2_rdy;
  // Receive FIFO
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic       rx_par_err;
  // Command channel
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_err;

  modport master (
    input  ps2_d_in, ps2_rdy, rx_pop, cmd_data, cmd_valid,
    output ps2_d_out, ps2_d_oe, ps2_n_sel, ps2_n_oe, ps2_n_we, ps2_a,
    output rx_data, rx_valid, rx_par_err, cmd_ready, cmd_done, cmd_err
  );

  modport slave (
    output ps2_d_in, ps2_rdy, rx_pop, cmd_data, cmd_valid,
    input  ps2_d_out, ps2_d_oe, ps2_n_sel, ps2_n_oe, ps2_n_we, ps2_a,
    input  rx_data, rx_valid, rx_par_err, cmd_ready, cmd_done, cmd_err
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: runs the port's CPU-style bus, drains scancodes into a
// FIFO with parity filtering, and sends single-byte commands resolving ACK/RESEND/timeout.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic           clk,
  input  logic           n_rst,
  ps2_kbd_ctrl_if.master bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {StIdle, StPoll, StRd, StClr, StSend, StWait} state_e;

  state_e         r_state, w_state_next;
  logic [1:0]     r_ph;          // 0 setup, 1 strobe, 2 hold, 3 deselect gap
  logic [1:0]     r_stat;        // {parity_ok, has_data}
  logic           r_rdy;
  logic [7:0]     r_data;
  logic [7:0]     r_cmd;
  logic           r_cmd_act;     // command outstanding
  logic           r_cmd_pend;    // send still to be issued
  logic           r_cmd_sent;    // at least one send issued, awaiting reply
  logic [RW-1:0]  r_retry;
  logic [TW-1:0]  r_to_cnt;
  logic           r_ready_en;
  logic           r_cmd_done, r_cmd_err, r_par_err;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_bus_state, w_acc_end, w_rd_end, w_full, w_pop, w_push, w_push_ok;
  logic           w_par_ok, w_is_reply, w_ack, w_resend, w_timeout, w_cmd_ready;
  logic [RW-1:0]  w_retry_inc;

  assign w_bus_state = (r_state == StPoll) || (r_state == StRd) ||
                       (r_state == StClr)  || (r_state == StSend);
  assign w_acc_end   = w_bus_state && (r_ph == 2'd3);
  assign w_rd_end    = (r_state == StRd) && (r_ph == 2'd3);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_pop       = bus.rx_pop && (r_count != '0);
  assign w_par_ok    = r_stat[1];
  // Only a well-formed byte arriving after a send is treated as a reply
  assign w_is_reply  = r_cmd_act && r_cmd_sent && w_par_ok;
  assign w_ack       = w_is_reply && (r_data == 8'hFA);
  assign w_resend    = w_is_reply && (r_data == 8'hFE);
  assign w_push      = w_rd_end && w_par_ok && !w_ack && !w_resend;
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_retry_inc = r_retry + RW'(1);
  assign w_timeout   = r_cmd_sent && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_cmd_ready = (r_state == StIdle) && !r_cmd_act && r_ready_en;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: w_state_next = StPoll;
      StPoll: begin
        if (w_acc_end) begin
          if (r_stat[0] && !w_full)     w_state_next = StRd;
          else if (r_cmd_pend && r_rdy) w_state_next = StSend;
          else if (r_cmd_act)           w_state_next = StWait;
          else                          w_state_next = StIdle;
        end
      end
      StRd:   if (w_acc_end) w_state_next = StClr;
      StClr:  if (w_acc_end) w_state_next = StPoll;
      StSend: if (w_acc_end) w_state_next = StWait;
      StWait: w_state_next = StPoll;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: bus strobes decoded from state and access phase, plus host-side views
  always_comb begin
    bus.ps2_n_sel  = 1'b1;
    bus.ps2_n_oe   = 1'b1;
    bus.ps2_n_we   = 1'b1;
    bus.ps2_a      = 1'b1;
    bus.ps2_d_oe   = 1'b0;
    bus.ps2_d_out  = 8'h00;
    if (w_bus_state && (r_ph != 2'd3)) begin
      bus.ps2_n_sel = 1'b0;
      unique case (r_state)
        StPoll: begin
          bus.ps2_a    = 1'b1;
          bus.ps2_n_oe = (r_ph != 2'd1);
        end
        StRd: begin
          bus.ps2_a    = 1'b0;
          bus.ps2_n_oe = (r_ph != 2'd1);
        end
        StClr: begin
          bus.ps2_a     = 1'b1;
          bus.ps2_d_oe  = 1'b1;
          bus.ps2_n_we  = (r_ph != 2'd1);
        end
        StSend: begin
          bus.ps2_a     = 1'b0;
          bus.ps2_d_oe  = 1'b1;
          bus.ps2_d_out = r_cmd;
          bus.ps2_n_we  = (r_ph != 2'd1);
        end
        default: ;
      endcase
    end
    bus.rx_data    = r_mem[r_rptr];
    bus.rx_valid   = (r_count != '0);
    bus.cmd_ready  = w_cmd_ready;
    bus.cmd_done   = r_cmd_done;
    bus.cmd_err    = r_cmd_err;
    bus.rx_par_err = r_par_err;
  end

  // Access phase counter; free states hold it at zero
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                              r_ph <= 2'd0;
    else if (w_bus_state && r_ph != 2'd3)    r_ph <= r_ph + 2'd1;
    else                                     r_ph <= 2'd0;
  end

  // Read data captured at the end of the strobe cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stat <= 2'b00;
      r_rdy  <= 1'b0;
      r_data <= 8'h00;
    end else if (r_ph == 2'd1) begin
      if (r_state == StPoll) begin
        r_stat <= bus.ps2_d_in[1:0];
        r_rdy  <= bus.ps2_rdy;
      end
      if (r_state == StRd) r_data <= bus.ps2_d_in;
    end
  end

  // Command tracking, reply resolution, timeout and result pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cmd      <= 8'h00;
      r_cmd_act  <= 1'b0;
      r_cmd_pend <= 1'b0;
      r_cmd_sent <= 1'b0;
      r_retry    <= '0;
      r_to_cnt   <= '0;
      r_ready_en <= 1'b0;
      r_cmd_done <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_cmd_done <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_par_err  <= w_rd_end && !w_par_ok;
      if (w_cmd_ready && bus.cmd_valid) begin
        r_cmd      <= bus.cmd_data;
        r_cmd_act  <= 1'b1;
        r_cmd_pend <= 1'b1;
        r_cmd_sent <= 1'b0;
        r_retry    <= '0;
      end else if (r_state == StSend && r_ph == 2'd0) begin
        // Count includes this setup cycle so the error lands TIMEOUT_CYCLES after SEND
        r_cmd_pend <= 1'b0;
        r_cmd_sent <= 1'b1;
        r_to_cnt   <= TW'(1);
      end else if (w_rd_end && w_ack) begin
        r_cmd_done <= 1'b1;
        r_cmd_act  <= 1'b0;
        r_cmd_pend <= 1'b0;
        r_cmd_sent <= 1'b0;
      end else if (w_rd_end && w_resend) begin
        r_retry <= w_retry_inc;
        if (w_retry_inc > RW'(MAX_RETRY)) begin
          r_cmd_err  <= 1'b1;
          r_cmd_act  <= 1'b0;
          r_cmd_pend <= 1'b0;
          r_cmd_sent <= 1'b0;
        end else begin
          r_cmd_pend <= 1'b1;
        end
      end else if (w_timeout) begin
        r_cmd_err  <= 1'b1;
        r_cmd_act  <= 1'b0;
        r_cmd_pend <= 1'b0;
        r_cmd_sent <= 1'b0;
      end else if (r_cmd_sent) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_data;
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a behavioural PS/2 port model plus a
// scoreboard of expected host-visible events (writes, pops, result pulses).
module tb_ps2_kbd_ctrl;
  localparam int unsigned TO = 200;
  localparam int K_CLR  = 1;
  localparam int K_CMD  = 2;
  localparam int K_RX   = 3;
  localparam int K_PAR  = 4;
  localparam int K_DONE = 5;
  localparam int K_ERR  = 6;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  ps2_kbd_ctrl_if ifc ();

  ps2_kbd_ctrl #(
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (3)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (ifc.master)
  );

  typedef struct {int kind; int data;} exp_t;
  exp_t       exp_q[$];
  logic [8:0] obs_wr[$];
  logic [8:0] m_rx_q[$];     // {parity_ok, byte}
  logic [8:0] m_replies[$];  // queued per command write
  logic       m_has = 1'b0;
  logic       m_par = 1'b0;
  logic       m_rdy = 1'b0;
  logic       m_prev_we = 1'b1;
  logic [7:0] m_data = 8'h00;
  int n_total = 0, n_pass = 0, cyc = 0;
  int m_sel_cnt = 0, m_data_reads = 0, m_cmd_writes = 0, m_clr_writes = 0;
  int m_send_cyc = 0, m_err_cyc = -1;

  assign ifc.ps2_d_in = ifc.ps2_a ? {6'b0, m_par, m_has} : m_data;
  assign ifc.ps2_rdy  = m_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic exp_push(input int k, input int d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input int data);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (e.data >= 0) chk("sb_data", data, e.data);
    end
  endtask

  // Port model: serves status/data reads, latches writes on n_we rising, checks access shape
  always @(negedge clk) begin
    logic [8:0] e;
    if (!n_rst) begin
      m_has     = 1'b0;
      m_sel_cnt = 0;
      m_prev_we = 1'b1;
    end else begin
      if (!ifc.ps2_n_sel) begin
        m_sel_cnt++;
        if (!ifc.ps2_n_oe || !ifc.ps2_n_we) chk("strobe_position", m_sel_cnt, 2);
        if (!ifc.ps2_n_oe && !ifc.ps2_a) m_data_reads++;
        if (!ifc.ps2_n_we && !ifc.ps2_a && m_prev_we) m_send_cyc = cyc;
        if (!m_prev_we && ifc.ps2_n_we) begin
          obs_wr.push_back({ifc.ps2_a, ifc.ps2_d_out});
          if (ifc.ps2_a) begin
            m_clr_writes++;
            m_has = 1'b0;
          end else begin
            m_cmd_writes++;
            if (m_replies.size() != 0) m_rx_q.push_back(m_replies.pop_front());
          end
        end
      end else if (m_sel_cnt != 0) begin
        chk("access_length", m_sel_cnt, 3);
        m_sel_cnt = 0;
      end
      m_prev_we = ifc.ps2_n_we;
      if (!m_has && m_rx_q.size() != 0) begin
        e      = m_rx_q.pop_front();
        m_par  = e[8];
        m_data = e[7:0];
        m_has  = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    logic [8:0] w;
    #1;
    if (n_rst) begin
      while (obs_wr.size() != 0) begin
        w = obs_wr.pop_front();
        if (w[8]) sb_check(K_CLR, int'(w[7:0]));
        else      sb_check(K_CMD, int'(w[7:0]));
      end
      if (ifc.rx_par_err) sb_check(K_PAR, 0);
      if (ifc.cmd_done)   sb_check(K_DONE, 0);
      if (ifc.cmd_err) begin
        sb_check(K_ERR, 0);
        m_err_cyc = cyc;
      end
      if (ifc.rx_pop && ifc.rx_valid) sb_check(K_RX, int'(ifc.rx_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx_valid(input string name);
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (ifc.rx_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, ok, 1);
  endtask

  task automatic issue_cmd(input logic [7:0] b);
    int ok = 0;
    ifc.cmd_data  = b;
    ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    tick();
    ifc.cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int r0, c0, w0;
    ifc.rx_pop    = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = 8'h00;
    repeat (3) tick();
    // Reset values
    chk("rst_n_sel", ifc.ps2_n_sel, 1);
    chk("rst_n_oe", ifc.ps2_n_oe, 1);
    chk("rst_n_we", ifc.ps2_n_we, 1);
    chk("rst_a", ifc.ps2_a, 1);
    chk("rst_d_oe", ifc.ps2_d_oe, 0);
    chk("rst_d_out", ifc.ps2_d_out, 0);
    chk("rst_rx_valid", ifc.rx_valid, 0);
    chk("rst_cmd_ready", ifc.cmd_ready, 0);
    chk("rst_pulses", {ifc.cmd_done, ifc.cmd_err, ifc.rx_par_err}, 0);
    n_rst = 1'b1;

    // Good byte: status read, data read, status clear write, then FIFO
    r0 = m_data_reads;
    exp_push(K_CLR, -1);
    m_rx_q.push_back({1'b1, 8'h1C});
    wait_rx_valid("t1_rx_valid");
    chk("t1_rx_data", int'(ifc.rx_data), 'h1C);
    repeat (8) tick();
    chk("t1_data_reads", m_data_reads - r0, 1);
    exp_push(K_RX, 'h1C);
    ifc.rx_pop = 1'b1;
    tick();
    ifc.rx_pop = 1'b0;

    // Bad parity: dropped with a pulse, clear still issued
    r0 = m_data_reads;
    exp_push(K_PAR, -1);
    exp_push(K_CLR, -1);
    m_rx_q.push_back({1'b0, 8'h55});
    repeat (40) tick();
    chk("t2_rx_valid", ifc.rx_valid, 0);
    chk("t2_data_reads", m_data_reads - r0, 1);

    // Command acknowledged; send held off until the port is ready
    w0 = m_cmd_writes;
    m_rdy = 1'b0;
    m_replies.push_back({1'b1, 8'hFA});
    exp_push(K_CMD, 'hED);
    exp_push(K_DONE, -1);
    exp_push(K_CLR, -1);
    issue_cmd(8'hED);
    repeat (30) tick();
    chk("t3_ready_busy", ifc.cmd_ready, 0);
    chk("t3_no_write_before_rdy", m_cmd_writes - w0, 0);
    m_rdy = 1'b1;
    repeat (80) tick();
    chk("t3_writes", m_cmd_writes - w0, 1);
    chk("t3_ack_not_queued", ifc.rx_valid, 0);

    // Resend four times: 1 + MAX_RETRY writes, then error
    w0 = m_cmd_writes;
    for (int i = 0; i < 4; i++) m_replies.push_back({1'b1, 8'hFE});
    for (int i = 0; i < 3; i++) begin
      exp_push(K_CMD, 'hFF);
      exp_push(K_CLR, -1);
    end
    exp_push(K_CMD, 'hFF);
    exp_push(K_ERR, -1);
    exp_push(K_CLR, -1);
    issue_cmd(8'hFF);
    repeat (250) tick();
    chk("t4_writes", m_cmd_writes - w0, 4);
    chk("t4_fifo_empty", ifc.rx_valid, 0);

    // FIFO full: ninth byte held in the port until a pop frees a slot
    r0 = m_data_reads;
    c0 = m_clr_writes;
    for (int i = 0; i < 8; i++) exp_push(K_CLR, -1);
    for (int i = 0; i < 9; i++) m_rx_q.push_back({1'b1, 8'h10 + 8'(i)});
    repeat (250) tick();
    chk("t5_reads_full", m_data_reads - r0, 8);
    chk("t5_clrs_full", m_clr_writes - c0, 8);
    chk("t5_has_data_held", m_has, 1);
    chk("t5_rx_valid", ifc.rx_valid, 1);
    exp_push(K_RX, 'h10);
    exp_push(K_CLR, -1);
    ifc.rx_pop = 1'b1;
    tick();
    ifc.rx_pop = 1'b0;
    repeat (40) tick();
    chk("t5_reads_after_pop", m_data_reads - r0, 9);
    chk("t5_clrs_after_pop", m_clr_writes - c0, 9);
    for (int i = 1; i < 9; i++) exp_push(K_RX, 'h10 + i);
    ifc.rx_pop = 1'b1;
    repeat (8) tick();
    ifc.rx_pop = 1'b0;
    chk("t5_drained", ifc.rx_valid, 0);

    // No reply: error after TIMEOUT_CYCLES
    m_rdy     = 1'b1;
    m_err_cyc = -1;
    exp_push(K_CMD, 'h55);
    exp_push(K_ERR, -1);
    issue_cmd(8'h55);
    repeat (TO + 60) tick();
    chk_rng("t6_timeout_cycles", m_err_cyc - m_send_cyc, int'(TO) - 3, int'(TO) + 3);

    // Reset during a read strobe: strobes release and FIFO flushes at once
    exp_push(K_CLR, -1);
    m_rx_q.push_back({1'b1, 8'h2A});
    wait_rx_valid("t7_rx_valid");
    repeat (8) tick();
    begin
      int ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!ifc.ps2_n_oe) begin
          ok = 1;
          break;
        end
      end
      chk("t7_found_strobe", ok, 1);
    end
    #2;
    n_rst = 1'b0;
    #1;
    chk("t7_n_sel", ifc.ps2_n_sel, 1);
    chk("t7_n_oe", ifc.ps2_n_oe, 1);
    chk("t7_n_we", ifc.ps2_n_we, 1);
    chk("t7_flushed", ifc.rx_valid, 0);
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (20) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Synchronous sequencer that owns the PS/2 port's CPU-style bus (d, n_oe, n_we, n_sel, a, rdy) and runs it on behalf of the system.
- Polls the port status, drains received scancodes into a small FIFO and checks their parity.
- Issues single-byte commands to the keyboard and resolves the reply: ACK 0xFA, RESEND 0xFE, or timeout.
- Sits between the PS/2 port and the CPU/interrupt logic, so software no longer bit-bangs status polling.

Parameters:
- FIFO_DEPTH, 8: scancode FIFO entries. Must be a power of two, at least 2.
- TIMEOUT_CYCLES, 200000: clk cycles a command may wait for a reply before failing.
- MAX_RETRY, 3: number of resends honoured per command.

Ports:
- clk  in  1: system clock. All state changes on the rising edge.
- n_rst  in  1: asynchronous, active-low reset.
- ps2_d_in  in  8: port data bus, read direction.
- ps2_d_out  out  8: port data bus, write direction.
- ps2_d_oe  out  1: enables ps2_d_out onto the bus.
- ps2_n_sel  out  1: port select, active low.
- ps2_n_oe  out  1: read strobe, active low.
- ps2_n_we  out  1: write strobe, active low.
- ps2_a  out  1: register select. 0 = data, 1 = status.
- ps2_rdy  in  1: port idle indication, meaningful only while ps2_n_sel=0.
- rx_data  out  8: FIFO head byte.
- rx_valid  out  1: FIFO not empty.
- rx_pop  in  1: dequeue the head byte when rx_valid=1.
- cmd_data  in  8: command byte to send.
- cmd_valid  in  1: command request.
- cmd_ready  out  1: controller can accept a command.
- cmd_done  out  1: 1-cycle pulse, command acknowledged with 0xFA.
- cmd_err  out  1: 1-cycle pulse, command failed (timeout or retries exhausted).
- rx_par_err  out  1: 1-cycle pulse, received byte dropped for bad parity.

Behaviour:
- Reset values:
  - ps2_n_sel, ps2_n_oe, ps2_n_we = 1; ps2_a = 1; ps2_d_oe = 0; ps2_d_out = 0.
  - FIFO empty, so rx_valid = 0.
  - cmd_ready = 0 until the first IDLE cycle.
  - All pulse outputs = 0. FSM = IDLE.
- Bus access: always 3 cycles.
  - SETUP: n_sel=0, a set.
  - STROBE: n_oe or n_we = 0.
  - HOLD: strobe = 1, n_sel still 0.
  - Read data is sampled at the end of STROBE.
  - For a write, ps2_d_oe=1 and ps2_d_out is stable in all 3 cycles. The port latches on n_we rising while n_sel=0.
  - n_sel returns to 1 for at least 1 cycle between accesses.
- Status byte: bit0 has_data, bit1 parity_ok, bit2 send_ack (0 = device acked). Bits 7:3 are ignored.
- FSM states:
  - IDLE: cmd_ready = 1 only here, and only with no command outstanding. Always go to POLL; latch cmd_data if cmd_valid.
  - POLL: status read.
    - If has_data and the FIFO is not full: go to RD.
    - Else if a command is pending and ps2_rdy=1 (sampled in STROBE): go to SEND.
    - Else if in a command: go to WAIT.
    - Else go to IDLE.
  - RD: data read, then CLR.
    - Push the byte if parity_ok. Otherwise pulse rx_par_err and do not push.
    - In a command, 0xFA: pulse cmd_done, do not push, end the command.
    - In a command, 0xFE: retry_cnt+1. If retry_cnt > MAX_RETRY, pulse cmd_err; else re-arm the send.
    - Other bytes are pushed normally.
  - CLR: status write with any data; clears has_data. Then POLL.
  - SEND: data write of the latched command. Clear and start the timeout counter. Then WAIT.
  - WAIT: return to POLL. The timeout counter runs from SEND until the reply. Reaching TIMEOUT_CYCLES pulses cmd_err and ends the command.
- Priority and boundaries:
  - Received bytes take priority over starting a send.
  - FIFO full: has_data is left set. The port keeps the PS/2 clock low (device inhibited), so no data is lost. Polling continues.
  - rx_pop and push in the same cycle with the FIFO full is allowed; the count is unchanged.
  - rx_pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_valid outside IDLE is ignored; the requester holds it until cmd_ready.
  - Reset asserted mid-access: strobes return to 1 immediately (async), the FIFO is flushed and any command is abandoned with no pulses.

Test Plan:
- Reset, then a model port presents status 0x03 and data 0x1C.
  - Bus: read a=1, read a=0, write a=1, each 3 cycles.
  - Result: rx_valid=1, rx_data=0x1C.
- Status 0x01 (parity bad) with data 0x55.
  - Result: rx_par_err pulses once, FIFO stays empty, the CLR write still occurs.
- cmd 0xED with the model replying 0xFA.
  - Result: write of 0xED on a=0 only after ps2_rdy=1; cmd_done pulses; 0xFA is not in the FIFO.
- cmd 0xFF with the model replying 0xFE ×4.
  - Result: 4 writes of 0xFF total (1 + MAX_RETRY), then cmd_err; no cmd_done.
- Push 8 bytes with no pops, then a 9th with has_data held.
  - Result: no 9th data read and no CLR.
  - After one rx_pop, the 9th byte is read and FIFO order is preserved.
- cmd sent with no reply.
  - Result: cmd_err exactly TIMEOUT_CYCLES ±3 cycles after SEND.
  - Assert n_rst mid-STROBE: all strobes go high asynchronously.
